// File: rtl/quadencoder_velocity.sv
`default_nettype none
// ============================================================================
// Module      : quadencoder_velocity
// Description : Gated velocity measurement for a quadrature decoder. Counts
//               position change over a programmable window of clk cycles,
//               saturates the result into a narrower signed output, and
//               compensates for the decoder clearing position on index.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1          clock, all logic on rising edge
//   rst_n        in   1          synchronous active-low reset
//   position     in   BITS       signed decoder count (same clock domain)
//   indexout     in   1          index-armed flag; 1->0 = position cleared
//   gate_cycles  in   GATE_BITS  window length in cycles, 0 = disabled
//   velocity     out  VBITS      signed delta over last completed window
//   valid        out  1          one-cycle strobe on velocity update
//   saturated    out  1          sticky: some window delta was clamped
// ============================================================================
module quadencoder_velocity #(
  parameter int BITS      = 32,
  parameter int VBITS     = 16,
  parameter int GATE_BITS = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [BITS-1:0]  position,
  input  logic                    indexout,
  input  logic [GATE_BITS-1:0]    gate_cycles,
  output logic signed [VBITS-1:0] velocity,
  output logic                    valid,
  output logic                    saturated
);

  // Clamp limits expressed at full position width so the comparison is exact.
  localparam logic signed [BITS-1:0] c_VMAX =
    $signed({{(BITS-VBITS+1){1'b0}}, {(VBITS-1){1'b1}}});
  localparam logic signed [BITS-1:0] c_VMIN = ~c_VMAX;
  localparam logic [GATE_BITS-1:0]   c_GATE_ONE = GATE_BITS'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  logic signed [BITS-1:0]   r_pos_d;
  logic                     r_idx_d;
  logic signed [BITS-1:0]   r_ref;
  logic [GATE_BITS-1:0]     r_gate_cnt;
  logic                     r_primed;
  logic signed [VBITS-1:0]  r_velocity;
  logic                     r_valid;
  logic                     r_saturated;

  logic                     w_idx_fall;
  logic                     w_gate_off;
  logic [GATE_BITS-1:0]     w_reload;
  logic signed [BITS-1:0]   w_ref_comp;
  logic signed [BITS-1:0]   w_delta;
  logic                     w_over;
  logic                     w_under;
  logic signed [VBITS-1:0]  w_vel_sat;

  // The decoder clears position in the same cycle indexout falls, so the
  // registered pos_d still holds the last pre-clear count here.
  assign w_idx_fall = r_idx_d & ~indexout;
  assign w_gate_off = (gate_cycles == '0);
  assign w_reload   = gate_cycles - c_GATE_ONE;

  // Shifting ref down by the pre-clear count keeps (pos - ref) continuous
  // across the jump to zero.
  assign w_ref_comp = r_ref - r_pos_d;

  // When the index fires on the window-end cycle the compensated ref never
  // gets stored, so the delta is taken against it directly using the
  // already-cleared raw position. Arithmetic wraps modulo 2^BITS.
  assign w_delta = w_idx_fall ? (position - w_ref_comp) : (r_pos_d - r_ref);

  assign w_over  = (w_delta > c_VMAX);
  assign w_under = (w_delta < c_VMIN);

  always_comb begin
    w_vel_sat = w_delta[VBITS-1:0];
    if (w_over) begin
      w_vel_sat = c_VMAX[VBITS-1:0];
    end else if (w_under) begin
      w_vel_sat = c_VMIN[VBITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pos_d     <= '0;
      r_idx_d     <= 1'b0;
      r_ref       <= '0;
      r_gate_cnt  <= '0;
      r_primed    <= 1'b0;
      r_velocity  <= '0;
      r_valid     <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_pos_d  <= position;
      r_idx_d  <= indexout;
      // pos_d holds the reset value on the first cycle after release; the
      // window start waits one cycle so ref is loaded from a real sample.
      r_primed <= 1'b1;
      r_valid  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_gate_cnt <= '0;
          r_ref      <= r_pos_d;
          if (!w_gate_off && r_primed) begin
            r_state    <= ST_RUN;
            r_gate_cnt <= w_reload;
            // Index clearing on the start cycle: the corrected start point
            // is pos_d - pos_d, i.e. the cleared value.
            if (w_idx_fall) begin
              r_ref <= '0;
            end
          end
        end

        ST_RUN: begin
          if (w_gate_off) begin
            // Disabling abandons the open window without a result.
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_ref      <= r_pos_d;
          end else if (r_gate_cnt == '0) begin
            r_velocity <= w_vel_sat;
            r_valid    <= 1'b1;
            if (w_over || w_under) begin
              r_saturated <= 1'b1;
            end
            r_ref      <= w_idx_fall ? position : r_pos_d;
            // A changed gate_cycles is picked up only here.
            r_gate_cnt <= w_reload;
          end else begin
            r_gate_cnt <= r_gate_cnt - c_GATE_ONE;
            if (w_idx_fall) begin
              r_ref <= w_ref_comp;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign velocity  = r_velocity;
  assign valid     = r_valid;
  assign saturated = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_quadencoder_velocity.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadencoder_velocity
// Description : Directed self-checking bench for quadencoder_velocity
//               (BITS=32, VBITS=16, GATE_BITS=24).
// Revision    : 1.0  initial release
// ============================================================================
module tb_quadencoder_velocity;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] position;
  logic               indexout;
  logic [23:0]        gate_cycles;
  logic signed [15:0] velocity;
  logic               valid;
  logic               saturated;

  int errors;
  int checks;
  int cyc;
  int cyc0;
  int                 vcyc[$];
  logic signed [15:0] vval[$];

  quadencoder_velocity #(
    .BITS      (32),
    .VBITS     (16),
    .GATE_BITS (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .position    (position),
    .indexout    (indexout),
    .gate_cycles (gate_cycles),
    .velocity    (velocity),
    .valid       (valid),
    .saturated   (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are looked at 1 time unit after the edge and
  // every valid strobe is logged with the cycle number it appeared on.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      vcyc.push_back(cyc);
      vval.push_back(velocity);
    end
  endtask

  task automatic go_idle();
    gate_cycles = 24'd0;
    repeat (3) tick();
    vcyc.delete();
    vval.delete();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    position    = 32'sd77;
    indexout    = 1'b1;
    gate_cycles = 24'd0;
    repeat (3) tick();
    checks++;
    if (velocity !== 16'sd0) begin
      errors++; $display("FAIL reset_velocity: got %0d expected 0", velocity);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", valid);
    end
    checks++;
    if (saturated !== 1'b0) begin
      errors++; $display("FAIL reset_saturated: got %b expected 0", saturated);
    end
    rst_n    = 1'b1;
    indexout = 1'b0;
    vcyc.delete();
    vval.delete();
    repeat (5) tick();
    checks++;
    if (vcyc.size() != 0) begin
      errors++; $display("FAIL idle_no_valid: got %0d strobes expected 0", vcyc.size());
    end
  endtask

  // Window 100, +3 every 10 cycles: 30 per window, strobes 100 apart.
  task automatic test_ramp();
    int exp_c[3];
    exp_c = '{101, 201, 301};
    position = 32'sd1000;
    go_idle();
    gate_cycles = 24'd100;
    cyc0 = cyc;
    for (int i = 1; i <= 320; i++) begin
      if (i % 10 == 0) position = position + 32'sd3;
      tick();
    end
    checks++;
    if (vcyc.size() != 3) begin
      errors++; $display("FAIL ramp_count: got %0d expected 3", vcyc.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= vcyc.size() || vcyc[k] != cyc0 + exp_c[k] || vval[k] !== 16'sd30) begin
        errors++;
        $display("FAIL ramp_window%0d: got cycle %0d velocity %0d expected cycle %0d velocity 30",
                 k, (k < vcyc.size()) ? vcyc[k] - cyc0 : -1, (k < vval.size()) ? vval[k] : 16'sd0, exp_c[k]);
      end
    end
    checks++;
    if (saturated !== 1'b0) begin
      errors++; $display("FAIL ramp_saturated: got %b expected 0", saturated);
    end
  endtask

  // Window of 1 cycle: strobe every cycle carrying the per-cycle step.
  task automatic test_gate1();
    go_idle();
    gate_cycles = 24'd1;
    cyc0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      position = position + 32'sd7;
      tick();
    end
    checks++;
    if (vcyc.size() != 7) begin
      errors++; $display("FAIL gate1_count: got %0d expected 7", vcyc.size());
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= vcyc.size() || vcyc[k] != cyc0 + 2 + k || vval[k] !== 16'sd7) begin
        errors++;
        $display("FAIL gate1_step%0d: got cycle %0d velocity %0d expected cycle %0d velocity 7",
                 k, (k < vcyc.size()) ? vcyc[k] - cyc0 : -1, (k < vval.size()) ? vval[k] : 16'sd0, k + 2);
      end
    end
  endtask

  // Signed wrap 0x7FFFFFF0 -> 0x80000010 is a +32 step.
  task automatic test_wrap();
    position = 32'sh7FFFFFF0;
    go_idle();
    gate_cycles = 24'd50;
    cyc0 = cyc;
    for (int i = 1; i <= 105; i++) begin
      if (i == 20) position = 32'sh80000010;
      tick();
    end
    checks++;
    if (vcyc.size() != 2 || vcyc[0] != cyc0 + 51 || vval[0] !== 16'sd32) begin
      errors++;
      $display("FAIL wrap_delta: got %0d strobes, first velocity %0d expected 2 strobes, first at 51 velocity 32",
               vcyc.size(), (vval.size() > 0) ? vval[0] : 16'sd0);
    end
    checks++;
    if (vval.size() < 2 || vval[1] !== 16'sd0) begin
      errors++; $display("FAIL wrap_hold: got velocity %0d expected 0", (vval.size() > 1) ? vval[1] : 16'sd0);
    end
  endtask

  // Index clear mid-window and on the window-end cycle; each window is +5.
  task automatic test_index();
    position = 32'sd500;
    indexout = 1'b1;
    go_idle();
    gate_cycles = 24'd20;
    cyc0 = cyc;
    for (int i = 1; i <= 85; i++) begin
      if (i == 8)  position = 32'sd505;
      if (i == 25) position = 32'sd510;
      if (i == 30) begin indexout = 1'b0; position = 32'sd0; end
      if (i == 45) position = 32'sd5;
      if (i == 50) indexout = 1'b1;
      if (i == 61) begin indexout = 1'b0; position = 32'sd0; end
      if (i == 70) position = 32'sd5;
      tick();
    end
    checks++;
    if (vcyc.size() != 4) begin
      errors++; $display("FAIL index_count: got %0d expected 4", vcyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= vcyc.size() || vcyc[k] != cyc0 + 21 + 20 * k || vval[k] !== 16'sd5) begin
        errors++;
        $display("FAIL index_window%0d: got cycle %0d velocity %0d expected cycle %0d velocity 5",
                 k, (k < vcyc.size()) ? vcyc[k] - cyc0 : -1, (k < vval.size()) ? vval[k] : 16'sd0, 21 + 20 * k);
      end
    end
  endtask

  // Gate 100 -> 20 mid-window takes effect at reload; gate -> 0 stops strobes.
  task automatic test_gate_change();
    int exp_c[3];
    logic signed [15:0] exp_v[3];
    exp_c = '{101, 121, 141};
    exp_v = '{16'sd11, 16'sd2, 16'sd4};
    position = 32'sd2000;
    go_idle();
    gate_cycles = 24'd100;
    cyc0 = cyc;
    for (int i = 1; i <= 200; i++) begin
      if (i == 30)  position = position + 32'sd11;
      if (i == 50)  gate_cycles = 24'd20;
      if (i == 110) position = position + 32'sd2;
      if (i == 130) position = position + 32'sd4;
      if (i == 150) gate_cycles = 24'd0;
      if (i == 155) position = position + 32'sd9;
      tick();
    end
    checks++;
    if (vcyc.size() != 3) begin
      errors++; $display("FAIL gatechg_count: got %0d expected 3", vcyc.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= vcyc.size() || vcyc[k] != cyc0 + exp_c[k] || vval[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL gatechg_window%0d: got cycle %0d velocity %0d expected cycle %0d velocity %0d",
                 k, (k < vcyc.size()) ? vcyc[k] - cyc0 : -1, (k < vval.size()) ? vval[k] : 16'sd0, exp_c[k], exp_v[k]);
      end
    end
    checks++;
    if (velocity !== 16'sd4) begin
      errors++; $display("FAIL gatechg_held: got %0d expected 4", velocity);
    end
  endtask

  // +40000 clamps to 32767 and sets the sticky flag; -40000 clamps to -32768.
  task automatic test_saturate();
    position = 32'sd0;
    go_idle();
    gate_cycles = 24'd20;
    cyc0 = cyc;
    for (int i = 1; i <= 65; i++) begin
      if (i == 5)  position = 32'sd40000;
      if (i == 25) position = 32'sd40010;
      if (i == 45) position = 32'sd10;
      tick();
      if (i == 21) begin
        checks++;
        if (valid !== 1'b1 || velocity !== 16'sd32767 || saturated !== 1'b1) begin
          errors++;
          $display("FAIL sat_pos: got valid %b velocity %0d saturated %b expected 1 32767 1", valid, velocity, saturated);
        end
      end
      if (i == 41) begin
        checks++;
        if (valid !== 1'b1 || velocity !== 16'sd10 || saturated !== 1'b1) begin
          errors++;
          $display("FAIL sat_sticky: got valid %b velocity %0d saturated %b expected 1 10 1", valid, velocity, saturated);
        end
      end
      if (i == 61) begin
        checks++;
        if (valid !== 1'b1 || velocity !== 16'sh8000) begin
          errors++;
          $display("FAIL sat_neg: got valid %b velocity %0d expected 1 -32768", valid, velocity);
        end
      end
    end
  endtask

  // Reset at window cycle 60 discards it; after release the window restarts
  // from the current position, not from 0.
  task automatic test_reset_midwindow();
    position = 32'sd1000;
    go_idle();
    gate_cycles = 24'd100;
    cyc0 = cyc;
    for (int i = 1; i <= 170; i++) begin
      if (i == 60)  rst_n = 1'b0;
      if (i == 61)  rst_n = 1'b1;
      if (i == 100) position = 32'sd1007;
      tick();
      if (i == 60) begin
        checks++;
        if (velocity !== 16'sd0 || valid !== 1'b0 || saturated !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_outputs: got velocity %0d valid %b saturated %b expected 0 0 0", velocity, valid, saturated);
        end
      end
    end
    checks++;
    if (vcyc.size() != 1 || vcyc[0] != cyc0 + 162 || vval[0] !== 16'sd7) begin
      errors++;
      $display("FAIL rstmid_window: got %0d strobes, first at %0d velocity %0d expected 1 strobe at 162 velocity 7",
               vcyc.size(), (vcyc.size() > 0) ? vcyc[0] - cyc0 : -1, (vval.size() > 0) ? vval[0] : 16'sd0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    test_reset();
    test_ramp();
    test_gate1();
    test_wrap();
    test_index();
    test_gate_change();
    test_saturate();
    test_reset_midwindow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/quadencoder_velocity.md
QUADENCODER_VELOCITY -- requirements
Module: quadencoder_velocity

Interface
REQ-001 SHALL have parameter BITS, default 32, width of the encoder position input.
REQ-002 SHALL have parameter VBITS, default 16, width of the velocity output, 2 <= VBITS <= BITS.
REQ-003 SHALL have parameter GATE_BITS, default 24, width of the gate-length input.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port position  input  BITS (signed)  count from the upstream quadrature decoder, same clock domain.
REQ-007 SHALL have port indexout  input  1  index-armed flag from the decoder; a 1->0 transition marks the cycle the decoder cleared position to 0.
REQ-008 SHALL have port gate_cycles  input  GATE_BITS  measurement window length in clk cycles; 0 = measurement disabled.
REQ-009 SHALL have port velocity  output  VBITS (signed)  position change over the last completed window.
REQ-010 SHALL have port valid  output  1  one-cycle strobe when velocity updates.
REQ-011 SHALL have port saturated  output  1  sticky flag, set when any window delta exceeded the VBITS range.

Function
REQ-012 SHALL register position and indexout once internally (pos_d, idx_d); all delta arithmetic SHALL use pos_d.
REQ-013 SHALL keep a down-counter gate_cnt; states IDLE (gate_cycles==0) and RUN (gate_cycles!=0).
REQ-014 In IDLE: gate_cnt held at 0, valid=0, velocity held, ref=pos_d each cycle.
REQ-015 On IDLE->RUN: gate_cnt loads gate_cycles-1, ref loads pos_d; first valid exactly gate_cycles cycles later.
REQ-016 In RUN, gate_cnt != 0: decrement by 1 per cycle.
REQ-017 In RUN, gate_cnt == 0 (window end): delta = pos_d - ref modulo 2^BITS; velocity <= sat(delta); valid <= 1 next cycle for one cycle only; ref <= pos_d; gate_cnt reloads gate_cycles-1.
REQ-018 Changes of gate_cycles while RUN SHALL take effect only at the next reload; a change to 0 SHALL enter IDLE the following cycle with no valid.
REQ-019 gate_cycles==1 SHALL produce valid every cycle, velocity = per-cycle delta.
REQ-020 Position wrap (e.g. 0x7FFFFFFF -> 0x80000000) SHALL yield delta +1, not a large negative value.
REQ-021 sat(): delta > 2^(VBITS-1)-1 -> 2^(VBITS-1)-1; delta < -2^(VBITS-1) -> -2^(VBITS-1); on clamp saturated <= 1 (sticky until reset).
REQ-022 Index compensation: on the cycle idx_d==1 and indexout==0, ref <= ref - pos_d, so the jump to 0 contributes no delta.
REQ-023 If index compensation and window end coincide, delta SHALL be computed as position - (ref - pos_d) and ref SHALL load position; no spurious jump in velocity.
REQ-024 Index compensation in IDLE SHALL have no visible effect (ref tracks pos_d).
REQ-025 Latency: position edge to inclusion in delta is 1 cycle (pos_d register); window end to valid is 1 cycle.

Reset
REQ-026 While rst_n==0 at a clk edge: velocity=0, valid=0, saturated=0, gate_cnt=0, ref=0, pos_d=0, idx_d=0, state IDLE.
REQ-027 Reset asserted mid-window SHALL discard the window; after release the first valid follows REQ-015 timing.
REQ-028 First window after reset SHALL use ref loaded from pos_d at IDLE->RUN, never ref=0 unless position is 0.

Verification
REQ-029 gate_cycles=100, position ramps +3 every 10 cycles -> valid every 100 cycles, velocity=30, saturated=0.
REQ-030 position steps 0x7FFFFFF0 -> 0x80000010 across one window, gate_cycles=50 -> velocity=+32.
REQ-031 VBITS=16, delta +40000 in one window -> velocity=32767, saturated=1 and stays 1 after later small deltas; delta -40000 -> -32768.
REQ-032 position at 500 rising +5/window, indexout falls and position clears to 0 mid-window -> that window's velocity unchanged (+5); coincident with window end -> also +5.
REQ-033 gate_cycles 100 -> 20 mid-window -> current window completes at 100, next at 20; gate_cycles -> 0 -> no further valid, velocity held.
REQ-034 rst_n low for 1 cycle at window cycle 60 -> all outputs 0, next valid exactly gate_cycles cycles after the IDLE->RUN transition following release.
